// File: rtl/moa_param_pipe_if.sv
// Operand-beat and result streams of the pipelined multi-operand adder.
// The producer/consumer side uses the master modport, the adder uses the slave modport.
interface moa_param_pipe_if #(
  parameter int NUM_OPS = 8,
  parameter int IN_W    = 8,
  parameter int ACC_EXT = 8
);
  localparam int OUT_W = IN_W + $clog2(NUM_OPS) + ACC_EXT;

  logic                    in_valid;
  logic                    in_ready;
  logic [NUM_OPS*IN_W-1:0] in_data;
  logic                    in_signed;
  logic                    in_acc;
  logic                    in_last;
  logic                    out_valid;
  logic                    out_ready;
  logic [OUT_W-1:0]        out_data;
  logic [7:0]              out_beats;

  modport master (
    output in_valid, in_data, in_signed, in_acc, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_beats
  );

  modport slave (
    input  in_valid, in_data, in_signed, in_acc, in_last, out_ready,
    output in_ready, out_valid, out_data, out_beats
  );
endinterface

// File: rtl/moa_param_pipe.sv
// Two-stage pipelined multi-operand adder: a 4:2 compressor tree (S1) followed by a
// carry-propagate add with optional multi-beat accumulation into the output register (S2).
module moa_param_pipe #(
  parameter int NUM_OPS = 8,
  parameter int IN_W    = 8,
  parameter int ACC_EXT = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  moa_param_pipe_if.slave bus
);
  localparam int OUT_W  = IN_W + $clog2(NUM_OPS) + ACC_EXT;
  localparam int LEVELS = $clog2(NUM_OPS) - 1;

  logic en;
  assign en           = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = en;

  // Each level halves the vector count; NUM_OPS is a power of two >= 4, so every
  // level above the final pair holds a multiple of four vectors.
  for (genvar l = 0; l <= LEVELS; l++) begin : lvl_g
    localparam int N = NUM_OPS >> l;
    logic [N*OUT_W-1:0] v;

    if (l == 0) begin : ext_g
      for (genvar k = 0; k < NUM_OPS; k++) begin : op_g
        logic [IN_W-1:0] op;
        logic            sb;
        assign op = bus.in_data[k*IN_W +: IN_W];
        assign sb = op[IN_W-1] & bus.in_signed;
        assign v[k*OUT_W +: OUT_W] = {{(OUT_W-IN_W){sb}}, op};
      end
    end else begin : cmp_g
      for (genvar g = 0; g < N/2; g++) begin : grp_g
        logic [OUT_W-1:0] a, b, c, d, s1, c1;
        assign a  = lvl_g[l-1].v[(4*g+0)*OUT_W +: OUT_W];
        assign b  = lvl_g[l-1].v[(4*g+1)*OUT_W +: OUT_W];
        assign c  = lvl_g[l-1].v[(4*g+2)*OUT_W +: OUT_W];
        assign d  = lvl_g[l-1].v[(4*g+3)*OUT_W +: OUT_W];
        assign s1 = a ^ b ^ c;
        assign c1 = ((a & b) | (a & c) | (b & c)) << 1;
        assign v[(2*g)*OUT_W +: OUT_W]   = s1 ^ c1 ^ d;
        assign v[(2*g+1)*OUT_W +: OUT_W] = ((s1 & c1) | (s1 & d) | (c1 & d)) << 1;
      end
    end
  end

  logic [OUT_W-1:0] tree_sum, tree_carry;
  assign tree_sum   = lvl_g[LEVELS].v[OUT_W-1:0];
  assign tree_carry = lvl_g[LEVELS].v[2*OUT_W-1:OUT_W];

  logic [OUT_W-1:0] s1_sum, s1_carry;
  logic             s1_valid, s1_acc, s1_last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_sum   <= '0;
      s1_carry <= '0;
      s1_valid <= 1'b0;
      s1_acc   <= 1'b0;
      s1_last  <= 1'b0;
    end else if (en) begin
      s1_sum   <= tree_sum;
      s1_carry <= tree_carry;
      s1_valid <= bus.in_valid;
      s1_acc   <= bus.in_acc;
      s1_last  <= bus.in_last;
    end
  end

  logic [OUT_W-1:0] acc_reg;
  logic [7:0]       beat_cnt;
  logic [OUT_W-1:0] total;
  logic [7:0]       cnt_inc;

  assign total   = s1_sum + s1_carry + (s1_acc ? acc_reg : '0);
  assign cnt_inc = (beat_cnt == 8'hFF) ? 8'hFF : beat_cnt + 8'd1;

  // A stalled output blocks the whole pipe, so the accumulator never runs ahead of it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_reg       <= '0;
      beat_cnt      <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_beats <= '0;
    end else if (en) begin
      if (s1_valid && !s1_acc) begin
        bus.out_valid <= 1'b1;
        bus.out_data  <= total;
        bus.out_beats <= 8'd1;
      end else if (s1_valid && !s1_last) begin
        acc_reg       <= total;
        beat_cnt      <= cnt_inc;
        bus.out_valid <= 1'b0;
      end else if (s1_valid) begin
        bus.out_valid <= 1'b1;
        bus.out_data  <= total;
        bus.out_beats <= cnt_inc;
        acc_reg       <= '0;
        beat_cnt      <= '0;
      end else begin
        bus.out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_moa_param_pipe.sv
// Directed bench for moa_param_pipe: the driver queues hand-computed results, and a
// monitor pops and compares them on every accepted output, plus stall-stability checks.
module tb_moa_param_pipe;
  localparam int NUM_OPS = 8;
  localparam int IN_W    = 8;
  localparam int ACC_EXT = 8;
  localparam int OUT_W   = IN_W + $clog2(NUM_OPS) + ACC_EXT;
  localparam int DW      = NUM_OPS * IN_W;

  typedef struct {
    logic [OUT_W-1:0] d;
    logic [7:0]       b;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  moa_param_pipe_if #(.NUM_OPS(NUM_OPS), .IN_W(IN_W), .ACC_EXT(ACC_EXT)) bus ();

  moa_param_pipe #(.NUM_OPS(NUM_OPS), .IN_W(IN_W), .ACC_EXT(ACC_EXT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Holds the beat until accepted; queues a result only for beats that close a result.
  task automatic apply_stimulus(input logic [DW-1:0] data, input logic sgn, input logic acc,
                                input logic last, input bit push,
                                input logic [OUT_W-1:0] exp_d, input logic [7:0] exp_b);
    bit accepted = 0;
    int waited = 0;
    exp_t e;
    bus.in_valid  = 1'b1;
    bus.in_data   = data;
    bus.in_signed = sgn;
    bus.in_acc    = acc;
    bus.in_last   = last;
    while (!accepted && waited <= 50) begin
      @(negedge clk);
      accepted = bus.in_ready;
      @(posedge clk);
      #1;
      waited++;
    end
    if (!accepted) begin
      checks++;
      errors++;
      $display("[TB] FAIL in_ready timeout: got 0, expected 1");
    end else if (push) begin
      e.d = exp_d;
      e.b = exp_b;
      exp_q.push_back(e);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state();
    check_output("rst out_valid", 32'(bus.out_valid), 32'd0);
    check_output("rst out_data", 32'(bus.out_data), 32'd0);
    check_output("rst out_beats", 32'(bus.out_beats), 32'd0);
    check_output("rst in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  logic             stall_seen = 1'b0;
  logic [OUT_W-1:0] stall_data;
  logic [7:0]       stall_beats;

  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      if (bus.out_ready) begin
        stall_seen = 1'b0;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected result: got 0x%0h, expected none", bus.out_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check_output("out_data", 32'(bus.out_data), 32'(e.d));
          check_output("out_beats", 32'(bus.out_beats), 32'(e.b));
        end
      end else begin
        check_output("stall in_ready", 32'(bus.in_ready), 32'd0);
        if (stall_seen) begin
          check_output("stall out_data", 32'(bus.out_data), 32'(stall_data));
          check_output("stall out_beats", 32'(bus.out_beats), 32'(stall_beats));
        end
        stall_seen  = 1'b1;
        stall_data  = bus.out_data;
        stall_beats = bus.out_beats;
      end
    end else begin
      stall_seen = 1'b0;
    end
  end

  initial begin
    int waited;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_signed = 1'b0;
    bus.in_acc    = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    idle_cycles(3);
    rst_n = 1'b1;
    idle_cycles(1);
    check_reset_state();

    $display("[TB] single unsigned and signed beats");
    apply_stimulus(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1, 19'd2040, 8'd1);
    apply_stimulus(64'h8080_8080_8080_8080, 1'b1, 1'b0, 1'b0, 1, 19'h7FC00, 8'd1);
    idle_cycles(4);

    $display("[TB] three-beat accumulation");
    apply_stimulus(64'h0807_0605_0403_0201, 1'b0, 1'b1, 1'b0, 0, '0, 8'd0);
    apply_stimulus(64'h0807_0605_0403_0201, 1'b0, 1'b1, 1'b0, 0, '0, 8'd0);
    apply_stimulus(64'h0807_0605_0403_0201, 1'b0, 1'b1, 1'b1, 1, 19'd108, 8'd3);
    idle_cycles(4);

    $display("[TB] backpressure on a five-beat stream");
    fork
      begin
        apply_stimulus(64'h0000_0000_0000_0001, 1'b0, 1'b0, 1'b0, 1, 19'd1, 8'd1);
        apply_stimulus(64'h0000_0000_0000_0101, 1'b0, 1'b0, 1'b0, 1, 19'd2, 8'd1);
        apply_stimulus(64'h0000_0000_0001_0101, 1'b0, 1'b0, 1'b0, 1, 19'd3, 8'd1);
        apply_stimulus(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 1, 19'h7FFF8, 8'd1);
        apply_stimulus(64'h0000_0000_0000_0505, 1'b0, 1'b0, 1'b0, 1, 19'd10, 8'd1);
      end
      begin
        idle_cycles(2);
        bus.out_ready = 1'b0;
        idle_cycles(4);
        bus.out_ready = 1'b1;
      end
    join
    idle_cycles(4);

    $display("[TB] non-acc beat interleaved in a packet");
    apply_stimulus(64'h0000_0000_0403_0201, 1'b0, 1'b1, 1'b0, 0, '0, 8'd0);
    apply_stimulus(64'h0000_0000_0000_0007, 1'b0, 1'b0, 1'b0, 1, 19'd7, 8'd1);
    apply_stimulus(64'h0000_0000_0000_0005, 1'b0, 1'b1, 1'b1, 1, 19'd15, 8'd2);
    idle_cycles(4);

    $display("[TB] mixed signed/unsigned packet");
    apply_stimulus(64'h8080_8080_8080_8080, 1'b1, 1'b1, 1'b0, 0, '0, 8'd0);
    apply_stimulus(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b1, 1, 19'd1016, 8'd2);
    idle_cycles(4);

    $display("[TB] beat counter saturation");
    for (int i = 0; i < 299; i++)
      apply_stimulus(64'h0000_0000_0000_0001, 1'b0, 1'b1, 1'b0, 0, '0, 8'd0);
    apply_stimulus(64'h0000_0000_0000_0001, 1'b0, 1'b1, 1'b1, 1, 19'd300, 8'd255);
    idle_cycles(4);

    $display("[TB] reset mid-packet");
    apply_stimulus(64'h0000_0000_0000_0909, 1'b0, 1'b1, 1'b0, 0, '0, 8'd0);
    apply_stimulus(64'h0000_0000_0000_0909, 1'b0, 1'b1, 1'b0, 0, '0, 8'd0);
    rst_n = 1'b0;
    idle_cycles(1);
    rst_n = 1'b1;
    check_reset_state();
    apply_stimulus(64'h0000_0000_0000_0103, 1'b0, 1'b1, 1'b1, 1, 19'd4, 8'd1);

    waited = 0;
    while (exp_q.size() != 0 && waited < 200) begin
      idle_cycles(1);
      waited++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: got %0d results outstanding, expected 0", exp_q.size());
    end
    idle_cycles(4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
